uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with the UART transmitter: deserialises 8N1 frames
//  (idle high, 1 start bit low, 8 data bits LSB first, 1 stop bit high) from rx.
//  Each good byte goes into a one-entry holding register, drained over a
//  valid/ready handshake by the CPU-side consumer.
//  Detects start-bit glitches, framing errors and overrun.
// PARAMETERS
//  CLK_DIV  2  clk cycles per bit; must equal the transmitter's CLK_DIV; legal >= 2
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, synchronous, active-high
//  rx         in   1  serial input, asynchronous to clk, idle high
//  o_valid    out  1  holding register holds an unread byte
//  o_data     out  8  received byte; stable while o_valid=1
//  i_ready    in   1  consumer accepts o_data this cycle when o_valid=1
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overrun    out  1  1-cycle pulse: good byte dropped, holding register full
//  busy       out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, o_valid=0, o_data=0, frame_err=0, overrun=0,
//   counters=0. Reset mid-frame aborts the frame; no partial byte is delivered.
//  Input sync: rx goes through 2 flops (rx_s); all decisions use rx_s only.
//  HALF = CLK_DIV/2 (integer division). divcnt width $clog2(CLK_DIV)+1.
//  Timing: t0 = first cycle in IDLE with rx_s=0. Samples:
//   start bit at t0+HALF; data bit k (k=0..7) at t0+HALF+(k+1)*CLK_DIV;
//   stop bit at t0+HALF+9*CLK_DIV.
//  FSM:
//   IDLE:  rx_s=0 -> START, divcnt=0.
//   START: at start sample, rx_s=1 -> IDLE (glitch, no flags);
//          rx_s=0 -> DATA, divcnt=0, bitcnt=0.
//   DATA:  every CLK_DIV cycles, shreg <= {rx_s, shreg[7:1]}; bitcnt+1;
//          after the 8th bit -> STOP.
//   STOP:  at stop sample, rx_s=1 -> deliver byte, -> IDLE;
//          rx_s=0 -> frame_err pulse next cycle, byte discarded, -> BREAK.
//   BREAK: stays until rx_s=1, then -> IDLE. A held-low line gives one
//          frame_err only.
//  Delivery (registered, effective the cycle after the stop sample):
//   o_valid=0, or o_valid=1 with i_ready=1 in the same cycle:
//    o_data <= byte, o_valid <= 1.
//   o_valid=1 and i_ready=0: byte dropped, old o_data kept, overrun pulse.
//  Handshake: o_valid falls the cycle after o_valid&i_ready with no new byte.
//   o_data is don't-care to the consumer while o_valid=0.
//  A new frame may start in the IDLE cycle right after STOP; no dead time
//   beyond the stop bit is required. frame_err and overrun never assert together.
// TESTING
//  1 CLK_DIV=4: drive frame for 0xA5 from uart TX model, i_ready=1 -> o_valid
//    for exactly 1 cycle with o_data=0xA5, no flags.
//  2 CLK_DIV=8: rx low for 2 cycles then high -> busy returns to 0 after the
//    start sample; no o_valid, no frame_err.
//  3 CLK_DIV=4: 0x3C with stop bit forced low, then rx held low 50 cycles ->
//    exactly one frame_err pulse, no o_valid; busy=1 until rx high.
//  4 i_ready=0: send 0x11 then 0x22 -> o_data stays 0x11; one overrun pulse at
//    0x22 delivery; raising i_ready gives one handshake, then o_valid=0.
//  5 i_ready=1: back-to-back 0x00, 0xFF, 0x80 with no idle gap -> three
//    o_valid pulses carrying 0x00, 0xFF, 0x80 in order.
//  6 rst asserted at data bit 4 of 0x5A, then a clean 0xC3 -> only 0xC3 is
//    delivered; all outputs at reset values right after rst.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
//   o_valid  receiver -> consumer  holding register holds an unread byte
//   o_data   receiver -> consumer  received byte, stable while o_valid=1
//   i_ready  consumer -> receiver  consumer takes o_data this cycle
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;

  modport master (output o_valid, output o_data, input i_ready);
  modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
//   clk, rst   clock, synchronous active-high reset
//   rx         serial input (async, idle high)
//   bus        uart_rx_if.master: o_valid/o_data out, i_ready in
//   frame_err  1-cycle pulse, stop bit sampled low
//   overrun    1-cycle pulse, good byte dropped because holding reg full
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int CLK_DIV = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          rx_m, rx_s;
  logic [CW-1:0] divcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;

  // Two-flop synchroniser; resets to the idle (high) level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      divcnt      <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Drain; a delivery below in the same cycle overrides this.
      if (bus.o_valid && bus.i_ready) bus.o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            divcnt <= '0;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (divcnt == HALF_END) begin
            divcnt <= '0;
            if (rx_s) begin
              // Line went back high before mid start bit: glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end else begin
            divcnt <= divcnt + CW'(1);
          end
        end
        DATA: begin
          if (divcnt == BIT_END) begin
            divcnt <= '0;
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= STOP;
          end else begin
            divcnt <= divcnt + CW'(1);
          end
        end
        STOP: begin
          if (divcnt == BIT_END) begin
            divcnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!bus.o_valid || bus.i_ready) begin
                bus.o_data  <= shreg;
                bus.o_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= BRK;
              frame_err <= 1'b1;
            end
          end else begin
            divcnt <= divcnt + CW'(1);
          end
        end
        BRK: begin
          // Wait out a held-low line so it reports a single frame error.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (CLK_DIV=4 main instance, CLK_DIV=8
// instance for the start-glitch case). A frame-level model built on a history
// of the synchronised line predicts every output each cycle.
module tb_uart_rx;
  localparam int CD   = 4;
  localparam int HALF = CD / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx, rx8;
  logic fe, ov, bsy, fe8, ov8, bsy8;

  uart_rx_if bus ();
  uart_rx_if bus8 ();

  uart_rx #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus),
    .frame_err(fe), .overrun(ov), .busy(bsy)
  );
  uart_rx #(.CLK_DIV(8)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .bus(bus8),
    .frame_err(fe8), .overrun(ov8), .busy(bsy8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit         hist[int];
  int         cyc = 0;
  bit         m1 = 1'b1, ms = 1'b1;
  int         phase = 0;   // 0 idle, 1 inside a frame, 2 waiting out a break
  int         t0 = 0;
  bit         ev = 1'b0, efe = 1'b0, eov = 1'b0, ebusy = 1'b0;
  logic [7:0] ed = 8'h00;
  bit         started = 1'b0;

  // Runs at each edge: judges the cycle that just ended, yields the
  // expected outputs for the cycle now starting.
  task automatic model_step();
    bit sv, load, take;
    int off;
    logic [7:0] b;
    sv = ms;
    hist[cyc] = sv;
    efe = 1'b0;
    eov = 1'b0;
    load = 1'b0;
    b = 8'h00;
    if (rst) begin
      phase = 0; ev = 1'b0; ed = 8'h00; m1 = 1'b1; ms = 1'b1; started = 1'b1;
    end else begin
      take = ev && bus.i_ready;
      if (phase == 0) begin
        if (!sv) begin t0 = cyc; phase = 1; end
      end else if (phase == 1) begin
        off = cyc - t0;
        if (off == HALF && sv) phase = 0;
        else if (off == HALF + 9*CD) begin
          for (int k = 0; k < 8; k++) b[k] = hist[t0 + HALF + (k+1)*CD];
          if (sv) begin
            phase = 0;
            if (!ev || bus.i_ready) begin ed = b; load = 1'b1; end
            else eov = 1'b1;
          end else begin
            efe = 1'b1; phase = 2;
          end
        end
      end else begin
        if (sv) phase = 0;
      end
      if (load) ev = 1'b1;
      else if (take) ev = 1'b0;
      ms = m1;
      m1 = rx;
    end
    ebusy = (phase != 0);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare + monitor ----------------
  logic [7:0] got[$];
  int nvcyc = 0, nfe = 0, nov = 0, v8 = 0, f8 = 0, o8 = 0;
  bit b8seen = 1'b0;

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("o_valid", bus.o_valid, ev);
      if (ev) check("o_data", bus.o_data, ed);
      check("frame_err", fe, efe);
      check("overrun", ov, eov);
      check("busy", bsy, ebusy);
      if (bus.o_valid && bus.i_ready) got.push_back(bus.o_data);
      if (bus.o_valid) nvcyc++;
      if (fe) nfe++;
      if (ov) nov++;
      if (bus8.o_valid) v8++;
      if (fe8) f8++;
      if (ov8) o8++;
      if (bsy8) b8seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    rx = 1'b0; tick(CD);
    for (int k = 0; k < 8; k++) begin rx = b[k]; tick(CD); end
    rx = stop; tick(CD);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, v0, f0, o0;
    logic [7:0] b5a;
    rst = 1'b1; rx = 1'b1; rx8 = 1'b1;
    bus.i_ready = 1'b0; bus8.i_ready = 1'b1;
    tick(3);
    check("rst o_valid", bus.o_valid, 0);
    check("rst o_data", bus.o_data, 8'h00);
    check("rst busy", bsy, 0);
    rst = 1'b0;
    tick(2);

    // 1: single 0xA5, consumer ready
    bus.i_ready = 1'b1;
    g0 = got.size(); v0 = nvcyc; f0 = nfe; o0 = nov;
    send(8'hA5, 1'b1); tick(6);
    check("t1 count", got.size() - g0, 1);
    check("t1 byte", got[g0], 8'hA5);
    check("t1 valid cycles", nvcyc - v0, 1);
    check("t1 flags", (nfe - f0) + (nov - o0), 0);

    // 2: start glitch on the CLK_DIV=8 instance
    rx8 = 1'b0; tick(2); rx8 = 1'b1; tick(20);
    check("t2 busy seen", b8seen, 1);
    check("t2 busy idle", bsy8, 0);
    check("t2 valid", v8, 0);
    check("t2 frame_err", f8 + o8, 0);

    // 3: framing error then held-low line
    g0 = got.size(); f0 = nfe;
    send(8'h3C, 1'b0);
    tick(50);
    check("t3 busy in break", bsy, 1);
    rx = 1'b1; tick(6);
    check("t3 frame_err count", nfe - f0, 1);
    check("t3 no byte", got.size() - g0, 0);
    check("t3 busy released", bsy, 0);

    // 4: overrun with consumer stalled
    bus.i_ready = 1'b0;
    g0 = got.size(); o0 = nov;
    send(8'h11, 1'b1); tick(4);
    send(8'h22, 1'b1); tick(4);
    check("t4 held data", bus.o_data, 8'h11);
    check("t4 held valid", bus.o_valid, 1);
    check("t4 overrun count", nov - o0, 1);
    bus.i_ready = 1'b1; tick(1); bus.i_ready = 1'b0; tick(3);
    check("t4 handshakes", got.size() - g0, 1);
    check("t4 drained byte", got[g0], 8'h11);
    check("t4 valid low", bus.o_valid, 0);

    // 5: back-to-back frames, no idle gap
    bus.i_ready = 1'b1;
    g0 = got.size(); o0 = nov;
    send(8'h00, 1'b1); send(8'hFF, 1'b1); send(8'h80, 1'b1); tick(6);
    check("t5 count", got.size() - g0, 3);
    check("t5 byte0", got[g0], 8'h00);
    check("t5 byte1", got[g0+1], 8'hFF);
    check("t5 byte2", got[g0+2], 8'h80);
    check("t5 overrun", nov - o0, 0);

    // 6: reset during data bit 4 of 0x5A, then clean 0xC3
    g0 = got.size();
    b5a = 8'h5A;
    rx = 1'b0; tick(CD);
    for (int k = 0; k < 4; k++) begin rx = b5a[k]; tick(CD); end
    rx = b5a[4]; tick(2);
    rst = 1'b1; rx = 1'b1; tick(1);
    check("t6 rst o_valid", bus.o_valid, 0);
    check("t6 rst o_data", bus.o_data, 8'h00);
    check("t6 rst frame_err", fe, 0);
    check("t6 rst overrun", ov, 0);
    check("t6 rst busy", bsy, 0);
    tick(1); rst = 1'b0; tick(4);
    send(8'hC3, 1'b1); tick(6);
    check("t6 count", got.size() - g0, 1);
    check("t6 byte", got[g0], 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
